// File: rtl/hazard_unit_v.sv
// hazard_unit_v: pipeline hazard unit (forwarding, load-use and vector-memory stalls, stall profiling)
// Ports: Ra1D/Ra2D/Ra1E/Ra2E/WA3E/WA3M/WA3W register addresses; RegWriteM/RegWriteW write enables;
//   MemtoRegE load in E; MemAccessD/MemAccessE vector LW/SW in D/E.
//   ForwardAE/ForwardBE operand selects (00 regfile, 01 ResultW, 10 ALUOutM);
//   StallF/StallD/FlushE combined stall; MemBusy data memory occupied; StallCount saturating stall cycles.
module hazard_unit_v #(
  parameter int REG_W      = 5,
  parameter int VMEM_BEATS = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Ra1D,
  input  logic [REG_W-1:0] Ra2D,
  input  logic [REG_W-1:0] Ra1E,
  input  logic [REG_W-1:0] Ra2E,
  input  logic [REG_W-1:0] WA3E,
  input  logic [REG_W-1:0] WA3M,
  input  logic [REG_W-1:0] WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemAccessD,
  input  logic             MemAccessE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             MemBusy,
  output logic [CNT_W-1:0] StallCount
);
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic             ld_stall, mem_stall, stall;
  always_comb begin
    ForwardAE = (RegWriteM && Ra1E == WA3M) ? 2'b10 : (RegWriteW && Ra1E == WA3W) ? 2'b01 : 2'b00;
    ForwardBE = (RegWriteM && Ra2E == WA3M) ? 2'b10 : (RegWriteW && Ra2E == WA3W) ? 2'b01 : 2'b00;
    ld_stall  = MemtoRegE && (Ra1D == WA3E || Ra2D == WA3E);
    // cnt==1 is the last busy beat, so a D access may proceed and reach M just as memory frees up
    mem_stall = MemAccessD && (MemAccessE || cnt_q > 4'd1);
    stall     = ld_stall || mem_stall;
    cnt_d     = MemAccessE ? 4'(VMEM_BEATS - 1) : (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    scnt_d    = (stall && scnt_q != '1) ? scnt_q + CNT_W'(1) : scnt_q;
  end
  assign StallF     = stall;
  assign StallD     = stall;
  assign FlushE     = stall;
  assign MemBusy    = cnt_q != 4'd0;
  assign StallCount = scnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 4'd0;
      scnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      scnt_q <= scnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_unit_v.sv
// tb_hazard_unit_v: directed and randomized checks of hazard_unit_v against a timing-based model
module tb_hazard_unit_v;
  localparam int VB = 4;
  logic clk = 0, reset = 1;
  logic [4:0] ra1d = 0, ra2d = 0, ra1e = 0, ra2e = 0, wa3e = 0, wa3m = 0, wa3w = 0;
  logic rwm = 0, rww = 0, mtre = 0, mad = 0, mae = 0;
  logic [1:0] fae, fbe, fae4, fbe4;
  logic sf, sd, fe, mb, sf4, sd4, fe4, mb4;
  logic [15:0] sc;
  logic [3:0] sc4;
  int checks = 0, failures = 0;
  int n = 0, last = -100, exp_sc = 0, exp_sc4 = 0;
  always #5 clk = ~clk;
  hazard_unit_v dut (.clk(clk), .reset(reset), .Ra1D(ra1d), .Ra2D(ra2d), .Ra1E(ra1e), .Ra2E(ra2e),
    .WA3E(wa3e), .WA3M(wa3m), .WA3W(wa3w), .RegWriteM(rwm), .RegWriteW(rww), .MemtoRegE(mtre),
    .MemAccessD(mad), .MemAccessE(mae), .ForwardAE(fae), .ForwardBE(fbe), .StallF(sf), .StallD(sd),
    .FlushE(fe), .MemBusy(mb), .StallCount(sc));
  hazard_unit_v #(.CNT_W(4)) dut4 (.clk(clk), .reset(reset), .Ra1D(ra1d), .Ra2D(ra2d), .Ra1E(ra1e),
    .Ra2E(ra2e), .WA3E(wa3e), .WA3M(wa3m), .WA3W(wa3w), .RegWriteM(rwm), .RegWriteW(rww),
    .MemtoRegE(mtre), .MemAccessD(mad), .MemAccessE(mae), .ForwardAE(fae4), .ForwardBE(fbe4),
    .StallF(sf4), .StallD(sd4), .FlushE(fe4), .MemBusy(mb4), .StallCount(sc4));
  // occupancy left: an access leaving E at edge `last` keeps memory busy for VB-1 further edges
  function automatic int rem();
    int r = VB - 1 - (n - last);
    return r > 0 ? r : 0;
  endfunction
  function automatic logic [1:0] fwd(input logic [4:0] ra);
    if (rwm && ra == wa3m) return 2'b10;
    if (rww && ra == wa3w) return 2'b01;
    return 2'b00;
  endfunction
  function automatic logic stall_e();
    return (mtre && (ra1d == wa3e || ra2d == wa3e)) || (mad && (mae || rem() > 1));
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("fwdA", 32'(fae), 32'(fwd(ra1e)));
    chk("fwdB", 32'(fbe), 32'(fwd(ra2e)));
    chk("stallF", 32'(sf), 32'(stall_e()));
    chk("stallD", 32'(sd), 32'(stall_e()));
    chk("flushE", 32'(fe), 32'(stall_e()));
    chk("membusy", 32'(mb), 32'(rem() != 0));
    chk("membusy4", 32'(mb4), 32'(rem() != 0));
    chk("stallcnt", 32'(sc), 32'(exp_sc));
    chk("stallcnt4", 32'(sc4), 32'(exp_sc4));
  endtask
  task automatic cyc();
    logic s;
    #1 check_all();
    s = stall_e();
    @(posedge clk);
    if (!reset) begin
      n++;
      if (mae) last = n;
      if (s) begin
        exp_sc = exp_sc < 65535 ? exp_sc + 1 : exp_sc;
        exp_sc4 = exp_sc4 < 15 ? exp_sc4 + 1 : exp_sc4;
      end
    end
    @(negedge clk);
  endtask
  initial begin
    logic nd, s;
    int base;
    #1 chk("rst_membusy", 32'(mb), 0);
    chk("rst_stallcnt", 32'(sc), 0);
    repeat (2) @(negedge clk);
    reset = 0;
    // forwarding priority
    rwm = 1; wa3m = 7; rww = 1; wa3w = 7; ra1e = 7; ra2e = 3;
    #1 chk("prio_A_M", 32'(fae), 2);
    chk("prio_B_none", 32'(fbe), 0);
    cyc();
    rwm = 0;
    #1 chk("prio_A_W", 32'(fae), 1);
    cyc();
    // load-use: one stall cycle then the load leaves E
    mtre = 1; wa3e = 4; ra2d = 4; ra1d = 9;
    #1 chk("lduse_stall", 32'(sf), 1);
    cyc();
    mtre = 0;
    #1 chk("lduse_release", 32'(sf), 0);
    chk("lduse_count", 32'(sc), 1);
    cyc();
    // back-to-back vector accesses
    base = exp_sc;
    mae = 1; mad = 1;
    #1 chk("b2b_t", 32'(sf), 1);
    cyc();
    mae = 0;
    #1 chk("b2b_t1_stall", 32'(sf), 1);
    chk("b2b_t1_busy", 32'(mb), 1);
    cyc();
    #1 chk("b2b_t2_stall", 32'(sf), 1);
    cyc();
    #1 chk("b2b_t3_stall", 32'(sf), 0);
    chk("b2b_t3_busy", 32'(mb), 1);
    chk("b2b_count", 32'(sc), 32'(base + 3));
    cyc();
    mae = 1; mad = 0;
    cyc();
    mae = 0;
    repeat (4) cyc();
    // both stall causes in one cycle count once
    base = exp_sc;
    mtre = 1; wa3e = 4; ra1d = 4; mad = 1; mae = 1;
    cyc();
    #1 chk("combined_count", 32'(sc), 32'(base + 1));
    mtre = 0; mae = 0; mad = 0;
    repeat (4) cyc();
    // reset in mid-BUSY
    mae = 1;
    cyc();
    mae = 0;
    cyc();
    #2 reset = 1;
    #1 chk("rstmid_busy", 32'(mb), 0);
    chk("rstmid_count", 32'(sc), 0);
    chk("rstmid_count4", 32'(sc4), 0);
    last = -100; exp_sc = 0; exp_sc4 = 0;
    @(negedge clk);
    reset = 0;
    mad = 1;
    #1 chk("rstmid_nostall", 32'(sf), 0);
    cyc();
    mad = 0;
    // saturation of the 4-bit counter
    mtre = 1; wa3e = 2; ra1d = 2;
    repeat (20) cyc();
    #1 chk("sat4", 32'(sc4), 15);
    chk("nosat16", 32'(sc), 20);
    mtre = 0;
    // randomized traffic with a pipeline-consistent vector access stream
    for (int i = 0; i < 400; i++) begin
      {ra1d, ra2d, ra1e, ra2e} = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      {wa3e, wa3m, wa3w} = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rwm = 1'($urandom); rww = 1'($urandom); mtre = ($urandom_range(0, 3) == 0);
      checks++;
      assert (!(mae && rem() > 1)) else begin
        failures++;
        $error("FAIL invariant observed=%0d expected=0", rem());
      end
      s = stall_e();
      nd = ($urandom_range(0, 2) == 0);
      cyc();
      mae = s ? 1'b0 : mad;
      mad = s ? mad : nd;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_unit_v.md
Name: hazard_unit_v

Overview:
- Pipeline hazard unit for the vector processor. It is the consumer of the controller's hazard interface: it takes RegWriteM, RegWriteW, MemtoRegE and the register addresses, and produces FlushE, stall and forwarding selects.
- Resolves RAW hazards by forwarding, load-use hazards by stalling, and serialises multi-beat vector memory accesses with an occupancy counter.
- Keeps a saturating stall-cycle counter for profiling FIR kernels.

Parameters:
- REG_W, 5, register address width.
- VMEM_BEATS, 4, cycles one vector LW/SW occupies data memory from M onward. Legal range 2..15.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- Ra1D  in  REG_W  source register 1 of the instruction in D.
- Ra2D  in  REG_W  source register 2 of the instruction in D.
- Ra1E  in  REG_W  source register 1 of the instruction in E.
- Ra2E  in  REG_W  source register 2 of the instruction in E.
- WA3E  in  REG_W  destination register in E.
- WA3M  in  REG_W  destination register in M.
- WA3W  in  REG_W  destination register in W.
- RegWriteM  in  1  write-enable of the instruction in M, already condition-gated.
- RegWriteW  in  1  write-enable of the instruction in W.
- MemtoRegE  in  1  instruction in E is a load.
- MemAccessD  in  1  valid vector LW/SW in D.
- MemAccessE  in  1  valid vector LW/SW in E. Deasserted for bubbles.
- ForwardAE  out  2  source A select: 00 register file, 01 ResultW, 10 ALUOutM.
- ForwardBE  out  2  source B select, same encoding.
- StallF  out  1  hold PC.
- StallD  out  1  hold the D pipeline register.
- FlushE  out  1  insert a bubble into E.
- MemBusy  out  1  data memory occupied by a prior vector access.
- StallCount  out  CNT_W  saturating count of stalled cycles.

Behaviour:
Forwarding (combinational):
- ForwardAE = 10 if RegWriteM and Ra1E==WA3M.
- Else ForwardAE = 01 if RegWriteW and Ra1E==WA3W.
- Else ForwardAE = 00.
- ForwardBE uses the same rules with Ra2E.
- M has priority over W. Register 0 is not special.

Load-use stall (combinational):
- LdStall = MemtoRegE and (Ra1D==WA3E or Ra2D==WA3E).

Memory occupancy counter:
- Register cnt, 4 bits. Reset value 0.
- Each clk edge: if MemAccessE, cnt <= VMEM_BEATS-1. Else if cnt!=0, cnt <= cnt-1. Else hold.
- MemBusy = (cnt!=0), registered-derived.
- Two states: IDLE (cnt==0) and BUSY (cnt!=0). BUSY lasts VMEM_BEATS-1 cycles after the access leaves E.

Memory stall (combinational):
- MemStall = MemAccessD and (MemAccessE or cnt>1).
- Consequence: consecutive accesses enter M exactly VMEM_BEATS cycles apart.
- A D access while cnt==1 is not stalled. The reload caused by a new MemAccessE overrides the decrement.

Combined stall:
- Stall = LdStall or MemStall.
- StallF = StallD = FlushE = Stall.
- Both stall causes at once produce one stall cycle per cycle, not two.

Stall-cycle counter:
- StallCount increments by 1 on every clk edge where Stall==1.
- Saturates at all-ones and does not wrap.

Reset:
- Async assert clears cnt and StallCount immediately. MemBusy=0 and StallCount=0 while reset is high.
- Combinational outputs keep following their inputs during reset.
- Reset in mid-BUSY abandons the remaining occupancy. The first edge after deassertion sees cnt=0.

Invariant:
- MemAccessE while cnt>1 cannot occur, because MemStall prevents it.
- The bench asserts this never happens.

Test Plan:
1. Forwarding priority: RegWriteM=1, WA3M=7; RegWriteW=1, WA3W=7; Ra1E=7, Ra2E=3 -> ForwardAE=10, ForwardBE=00. Then set RegWriteM=0 -> ForwardAE=01.
2. Load-use: MemtoRegE=1, WA3E=4, Ra2D=4 -> StallF=StallD=FlushE=1 for exactly one cycle. StallCount goes 0->1.
3. Back-to-back vector accesses, VMEM_BEATS=4: access A in E at cycle t, access B in D at t.
   - B stalls at cycles t, t+1, t+2.
   - At t+3, cnt=1 and Stall=0.
   - MemBusy is high during t+1..t+3.
   - StallCount=3.
4. Combined causes: LdStall and MemStall both true in the same cycle -> Stall=1 and StallCount increments by 1 only.
5. Reset mid-BUSY: reset asserted at cnt=2 -> MemBusy=0 and StallCount=0 immediately, without waiting for a clock edge. After release, a MemAccessD is not stalled.
6. Saturation with CNT_W=4: hold Stall=1 for 20 cycles -> StallCount stops at 15.
